// File: rtl/alu_defs_pkg.sv
// Shared ALU function codes, MIPS opcode/funct/REGIMM encodings and the decoded-op record.
package alu_defs_pkg;

  localparam logic [5:0] FUN_ADD  = 6'b000000;
  localparam logic [5:0] FUN_SUB  = 6'b000001;
  localparam logic [5:0] FUN_AND  = 6'b011000;
  localparam logic [5:0] FUN_OR   = 6'b011110;
  localparam logic [5:0] FUN_XOR  = 6'b010110;
  localparam logic [5:0] FUN_NOR  = 6'b010001;
  localparam logic [5:0] FUN_PASS = 6'b011010;
  localparam logic [5:0] FUN_SLL  = 6'b100000;
  localparam logic [5:0] FUN_SRL  = 6'b100001;
  localparam logic [5:0] FUN_SRA  = 6'b100011;
  localparam logic [5:0] FUN_EQ   = 6'b110011;
  localparam logic [5:0] FUN_NEQ  = 6'b110001;
  localparam logic [5:0] FUN_LT   = 6'b110101;
  localparam logic [5:0] FUN_LEZ  = 6'b111101;
  localparam logic [5:0] FUN_GEZ  = 6'b111001;
  localparam logic [5:0] FUN_GTZ  = 6'b111111;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [4:0] RI_BLTZ = 5'd0;
  localparam logic [4:0] RI_BGEZ = 5'd1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fun;
    logic        sign;
    logic        illegal;
  } aluOp_t;

  // Shift functs share their low two bits between the immediate and variable forms.
  function automatic logic [5:0] shiftFun(input logic [1:0] kind);
    case (kind)
      2'b10:   return FUN_SRL;
      2'b11:   return FUN_SRA;
      default: return FUN_SLL;
    endcase
  endfunction

endpackage

// File: rtl/alu_fun_decode.sv
// Combinational decode of a MIPS instruction into ALU operands, function code and sign select.
module alu_fun_decode
  import alu_defs_pkg::*;
#(
  parameter logic [5:0] RESET_FUN = FUN_ADD
) (
  input  logic [31:0] iInstr,
  input  logic [31:0] iRs,
  input  logic [31:0] iRt,
  output aluOp_t      op
);

  logic [5:0]  opcode, funct;
  logic [4:0]  rtField, shamt;
  logic [15:0] imm;
  logic [31:0] se, ze;
  logic        unusedRsField;

  assign opcode        = iInstr[31:26];
  assign rtField       = iInstr[20:16];
  assign shamt         = iInstr[10:6];
  assign funct         = iInstr[5:0];
  assign imm           = iInstr[15:0];
  assign se            = {{16{imm[15]}}, imm};
  assign ze            = {16'b0, imm};
  assign unusedRsField = ^iInstr[25:21];

  // Anything not matched keeps the illegal default: zero operands, RESET_FUN, unsigned.
  always_comb begin
    op = '{a: '0, b: '0, fun: RESET_FUN, sign: 1'b0, illegal: 1'b0};
    case (opcode)
      OP_RTYPE: begin
        op.a = iRs;
        op.b = iRt;
        case (funct)
          F_ADD, F_ADDU: begin op.fun = FUN_ADD; op.sign = (funct == F_ADD); end
          F_SUB, F_SUBU: begin op.fun = FUN_SUB; op.sign = (funct == F_SUB); end
          F_AND:         op.fun = FUN_AND;
          F_OR:          op.fun = FUN_OR;
          F_XOR:         op.fun = FUN_XOR;
          F_NOR:         op.fun = FUN_NOR;
          F_SLT, F_SLTU: begin op.fun = FUN_LT; op.sign = (funct == F_SLT); end
          F_SLL, F_SRL, F_SRA: begin
            op.a   = {27'b0, shamt};
            op.fun = shiftFun(funct[1:0]);
          end
          F_SLLV, F_SRLV, F_SRAV: op.fun = shiftFun(funct[1:0]);
          default: begin op.a = '0; op.b = '0; op.illegal = 1'b1; end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin op.a = iRs; op.b = se; op.sign = (opcode == OP_ADDI); end
      OP_SLTI, OP_SLTIU: begin
        op.a = iRs; op.b = se; op.fun = FUN_LT; op.sign = (opcode == OP_SLTI);
      end
      OP_ANDI: begin op.a = iRs; op.b = ze; op.fun = FUN_AND; end
      OP_ORI:  begin op.a = iRs; op.b = ze; op.fun = FUN_OR;  end
      OP_XORI: begin op.a = iRs; op.b = ze; op.fun = FUN_XOR; end
      OP_LUI:  begin op.a = {imm, 16'b0}; op.fun = FUN_PASS; end
      OP_LW, OP_SW: begin op.a = iRs; op.b = se; op.fun = FUN_ADD; end
      OP_BEQ:  begin op.a = iRs; op.b = iRt; op.fun = FUN_EQ;  op.sign = 1'b1; end
      OP_BNE:  begin op.a = iRs; op.b = iRt; op.fun = FUN_NEQ; op.sign = 1'b1; end
      OP_BLEZ: begin op.a = iRs; op.fun = FUN_LEZ; op.sign = 1'b1; end
      OP_BGTZ: begin op.a = iRs; op.fun = FUN_GTZ; op.sign = 1'b1; end
      OP_REGIMM: begin
        case (rtField)
          RI_BLTZ: begin op.a = iRs; op.fun = FUN_LT;  op.sign = 1'b1; end
          RI_BGEZ: begin op.a = iRs; op.fun = FUN_GEZ; op.sign = 1'b1; end
          default: op.illegal = 1'b1;
        endcase
      end
      default: op.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: decodes into ALU controls and holds them in a single ID/EX register.
module alu_issue_stage
  import alu_defs_pkg::*;
#(
  parameter int         WIDTH     = 32,
  parameter logic [5:0] RESET_FUN = FUN_ADD
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iValid,
  output logic             oReady,
  input  logic [31:0]      iInstr,
  input  logic [WIDTH-1:0] iRs,
  input  logic [WIDTH-1:0] iRt,
  input  logic             iFlush,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oA,
  output logic [WIDTH-1:0] oB,
  output logic [5:0]       oALUFun,
  output logic             oSign,
  output logic             oIllegal
);

  aluOp_t dec, opQ;
  logic   vldQ, accept, drain;

  alu_fun_decode #(.RESET_FUN(RESET_FUN)) uDecode (
    .iInstr (iInstr),
    .iRs    (iRs),
    .iRt    (iRt),
    .op     (dec)
  );

  assign oReady = !vldQ || iReady;
  assign accept = iValid && oReady;
  assign drain  = vldQ && iReady;

  // Flush wins over a same-cycle accept; data only moves on a real accept so a stall is bit-stable.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      vldQ <= 1'b0;
      opQ  <= '{a: '0, b: '0, fun: RESET_FUN, sign: 1'b0, illegal: 1'b0};
    end else if (iFlush) begin
      vldQ <= 1'b0;
    end else if (accept) begin
      vldQ <= 1'b1;
      opQ  <= dec;
    end else if (drain) begin
      vldQ <= 1'b0;
    end
  end

  assign oValid   = vldQ;
  assign oA       = opQ.a;
  assign oB       = opQ.b;
  assign oALUFun  = opQ.fun;
  assign oSign    = opQ.sign;
  assign oIllegal = opQ.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed vectors with hand-computed ALU controls.
module tb_alu_issue_stage;

  logic        iClk = 1'b0, iReset = 1'b1, iValid = 1'b0, iFlush = 1'b0, iReady = 1'b1;
  logic [31:0] iInstr = '0, iRs = '0, iRt = '0;
  logic        oReady, oValid, oSign, oIllegal;
  logic [31:0] oA, oB;
  logic [5:0]  oALUFun;

  int nVec = 0, nErr = 0;

  typedef struct {
    string       name;
    logic [31:0] instr, rs, rt, a, b;
    logic [5:0]  fun;
    logic        sign, ill;
  } vec_t;

  vec_t sbQ[$];

  alu_issue_stage dut (
    .iClk(iClk), .iReset(iReset), .iValid(iValid), .oReady(oReady), .iInstr(iInstr),
    .iRs(iRs), .iRt(iRt), .iFlush(iFlush), .oValid(oValid), .iReady(iReady),
    .oA(oA), .oB(oB), .oALUFun(oALUFun), .oSign(oSign), .oIllegal(oIllegal)
  );

  always #5 iClk = ~iClk;

  function automatic logic [31:0] mkI(input logic [5:0] op, input logic [4:0] rt,
                                      input logic [15:0] imm);
    return {op, 5'd1, rt, imm};
  endfunction

  function automatic logic [31:0] mkR(input logic [5:0] funct, input logic [4:0] shamt);
    return {6'd0, 5'd1, 5'd2, 5'd3, shamt, funct};
  endfunction

  function automatic vec_t mk(input string n, input logic [31:0] instr, rs, rt, a, b,
                              input logic [5:0] fun, input logic sign, ill);
    vec_t v;
    v.name = n; v.instr = instr; v.rs = rs; v.rt = rt; v.a = a; v.b = b;
    v.fun = fun; v.sign = sign; v.ill = ill;
    return v;
  endfunction

  task automatic check(input string n, input logic ok, input string detail);
    nVec++;
    if (!ok) begin
      nErr++;
      $display("FAIL %s: %s", n, detail);
    end
  endtask

  task automatic checkOut(input vec_t v);
    check(v.name, oA == v.a && oB == v.b && oALUFun == v.fun && oSign == v.sign &&
          oIllegal == v.ill,
          $sformatf("got A=%h B=%h fun=%b sign=%b ill=%b, want A=%h B=%h fun=%b sign=%b ill=%b",
                    oA, oB, oALUFun, oSign, oIllegal, v.a, v.b, v.fun, v.sign, v.ill));
  endtask

  // Monitor: every transfer into EX is matched against the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge iClk);
      if (!iReset && oValid && iReady) begin
        if (sbQ.size() == 0) check("unexpected_issue", 1'b0, $sformatf("got A=%h fun=%b, want none", oA, oALUFun));
        else checkOut(sbQ.pop_front());
      end
    end
  end

  task automatic drive(input vec_t v, input logic rdy);
    iValid = 1'b1; iInstr = v.instr; iRs = v.rs; iRt = v.rt; iReady = rdy;
  endtask

  // Presents a word until accepted (bounded), then records its expected decode.
  task automatic send(input vec_t v, input logic rdy);
    int n;
    n = 0;
    drive(v, rdy);
    forever begin
      @(negedge iClk);
      if (oReady) begin
        @(posedge iClk); #1;
        sbQ.push_back(v);
        break;
      end
      @(posedge iClk); #1;
      n++;
      if (n > 50) begin check("send_timeout", 1'b0, "got no accept, want accept"); break; end
    end
    iValid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    iValid = 1'b0; iReady = 1'b1;
    repeat (cycles) begin @(posedge iClk); #1; end
  endtask

  vec_t vecs[$];
  vec_t vBeq, vAnd, vAddu, vXor, vBgtz;

  initial begin
    vecs.push_back(mk("addi_se",  mkI(6'h08, 5'd2, 16'hFFFF), 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 6'b000000, 1, 0));
    vecs.push_back(mk("ori_ze",   mkI(6'h0D, 5'd2, 16'h8000), 32'd5, 32'd0, 32'd5, 32'h00008000, 6'b011110, 0, 0));
    vecs.push_back(mk("lui",      mkI(6'h0F, 5'd2, 16'h1234), 32'd7, 32'd9, 32'h12340000, 32'd0, 6'b011010, 0, 0));
    vecs.push_back(mk("sll",      mkR(6'h00, 5'd5), 32'hDEAD, 32'd1, 32'd5, 32'd1, 6'b100000, 0, 0));
    vecs.push_back(mk("sltu",     mkR(6'h2B, 5'd0), 32'd3, 32'd7, 32'd3, 32'd7, 6'b110101, 0, 0));
    vecs.push_back(mk("sub",      mkR(6'h22, 5'd0), 32'd9, 32'd4, 32'd9, 32'd4, 6'b000001, 1, 0));
    vecs.push_back(mk("srav",     mkR(6'h07, 5'd0), 32'h24, 32'h80000000, 32'h24, 32'h80000000, 6'b100011, 0, 0));
    vecs.push_back(mk("sltiu_se", mkI(6'h0B, 5'd2, 16'h8001), 32'd2, 32'd0, 32'd2, 32'hFFFF8001, 6'b110101, 0, 0));
    vecs.push_back(mk("xori_ze",  mkI(6'h0E, 5'd2, 16'hFFFF), 32'd0, 32'd0, 32'd0, 32'h0000FFFF, 6'b010110, 0, 0));
    vecs.push_back(mk("lw",       mkI(6'h23, 5'd2, 16'h8000), 32'h1000, 32'd0, 32'h1000, 32'hFFFF8000, 6'b000000, 0, 0));
    vecs.push_back(mk("bgez",     mkI(6'h01, 5'd1, 16'h0004), 32'hFFFFFFFF, 32'h55, 32'hFFFFFFFF, 32'd0, 6'b111001, 1, 0));
    vecs.push_back(mk("bltz",     mkI(6'h01, 5'd0, 16'h0004), 32'h80, 32'h55, 32'h80, 32'd0, 6'b110101, 1, 0));
    vecs.push_back(mk("nor",      mkR(6'h27, 5'd0), 32'hF0, 32'h0F, 32'hF0, 32'h0F, 6'b010001, 0, 0));
    vecs.push_back(mk("ill_op3f", mkI(6'h3F, 5'd2, 16'h1234), 32'd5, 32'd6, 32'd0, 32'd0, 6'b000000, 0, 1));
    vecs.push_back(mk("ill_ri2",  mkI(6'h01, 5'd2, 16'h1234), 32'd5, 32'd6, 32'd0, 32'd0, 6'b000000, 0, 1));
    vecs.push_back(mk("ill_fn01", mkR(6'h01, 5'd0), 32'd5, 32'd6, 32'd0, 32'd0, 6'b000000, 0, 1));
    vBeq  = mk("beq",  {6'h04, 5'd1, 5'd2, 16'h0010}, 32'd1, 32'd2, 32'd1, 32'd2, 6'b110011, 1, 0);
    vAnd  = mk("and",  mkR(6'h24, 5'd0), 32'hAA, 32'h0F, 32'hAA, 32'h0F, 6'b011000, 0, 0);
    vAddu = mk("addu", mkR(6'h21, 5'd0), 32'd4, 32'd3, 32'd4, 32'd3, 6'b000000, 0, 0);
    vXor  = mk("xor",  mkR(6'h26, 5'd0), 32'd1, 32'd1, 32'd1, 32'd1, 6'b010110, 0, 0);
    vBgtz = mk("bgtz", mkI(6'h07, 5'd0, 16'h0002), 32'd3, 32'd0, 32'd3, 32'd0, 6'b111111, 1, 0);

    repeat (2) @(posedge iClk);
    #1 iReset = 1'b0;
    @(negedge iClk);
    check("reset_state", !oValid && oReady && oA == 0 && oB == 0 && oALUFun == 6'b000000 && !oSign && !oIllegal,
          $sformatf("got vld=%b rdy=%b A=%h B=%h fun=%b s=%b ill=%b, want 0 1 0 0 000000 0 0",
                    oValid, oReady, oA, oB, oALUFun, oSign, oIllegal));
    @(posedge iClk); #1;

    // Back-to-back issue at full throughput.
    foreach (vecs[i]) send(vecs[i], 1'b1);
    idle(2);

    // Stall: a new word waits while every output stays put.
    send(vBeq, 1'b0);
    drive(vAnd, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge iClk);
      check("stall_ready", oReady == 1'b0 && oValid == 1'b1, $sformatf("got rdy=%b vld=%b, want 0 1", oReady, oValid));
      checkOut(vBeq);
      @(posedge iClk); #1;
    end
    iReady = 1'b1;
    @(negedge iClk);
    check("stall_release", oReady == 1'b1, $sformatf("got rdy=%b, want 1", oReady));
    @(posedge iClk); #1;
    sbQ.push_back(vAnd);
    idle(2);

    // Flush beats a same-cycle accept; the held entry and the incoming word both vanish.
    send(vAddu, 1'b0);
    drive(vXor, 1'b0);
    iFlush = 1'b1;
    @(posedge iClk); #1;
    void'(sbQ.pop_back());
    iFlush = 1'b0; iValid = 1'b0;
    @(negedge iClk);
    check("flush_kill", oValid == 1'b0, $sformatf("got vld=%b, want 0", oValid));
    idle(2);
    @(negedge iClk);
    check("flush_no_issue", oValid == 1'b0, $sformatf("got vld=%b, want 0", oValid));
    @(posedge iClk); #1;

    // Asynchronous reset in the middle of a stall.
    send(vBgtz, 1'b0);
    drive(vAnd, 1'b0);
    @(negedge iClk);
    #2 iReset = 1'b1;
    #1;
    check("reset_async", oValid == 1'b0 && oA == 0 && oALUFun == 6'b000000 && !oSign,
          $sformatf("got vld=%b A=%h fun=%b s=%b, want 0 0 000000 0", oValid, oA, oALUFun, oSign));
    sbQ.delete();
    iValid = 1'b0; iReady = 1'b0;
    @(posedge iClk); #3 iReset = 1'b0;
    @(negedge iClk);
    check("reset_ready", oReady == 1'b1 && oValid == 1'b0, $sformatf("got rdy=%b vld=%b, want 1 0", oReady, oValid));
    @(posedge iClk); #1;

    send(vecs[0], 1'b1);
    idle(1);
    for (int w = 0; w < 20 && sbQ.size() != 0; w++) begin @(posedge iClk); #1; end
    check("drain_all", sbQ.size() == 0, $sformatf("got %0d pending, want 0", sbQ.size()));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
